// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - opcode/funct constants, FSM state, ALU op and instruction class types
package mips_cpu_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_HALT
  } iclass_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - combinational 32-bit add/sub/and/or/signed-slt unit
module mips_alu
  import mips_cpu_pkg::*;
(
  input  alu_op_t     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  always_comb begin
    o_y = i_a + i_b;
    case (i_op)
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_SLT: o_y = {31'd0, $signed(i_a) < $signed(i_b)};
      default: o_y = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_cpu.sv
// rtl/mips_multicycle_cpu.sv - multicycle MIPS subset core with internal instruction/data memories
// Define MIPS_CPU_BRANCH_EN to execute beq/bne/j; otherwise they retire as 4-cycle NOPs.
module mips_multicycle_cpu
  import mips_cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  parameter int OUT_ADDR   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   out,
  output logic                          out_valid,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          halted
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [31:0]    r_imem [IMEM_DEPTH];
  logic [31:0]    r_dmem [DMEM_DEPTH];
  logic [31:0]    r_regs [32];
  state_t         r_state;
  logic [IAW-1:0] r_pc;
  logic [31:0]    r_ir, r_a, r_b, r_alu, r_mdr, r_out;
  logic           r_out_valid, r_halted;

  logic [5:0]     w_op, w_fn;
  logic [4:0]     w_rs, w_rt, w_rd, w_wdst;
  logic [31:0]    w_imm, w_alu_b, w_alu_y, w_wdata;
  logic [DAW-1:0] w_exec_daddr, w_mem_daddr;
  iclass_t        w_cls;
  alu_op_t        w_alu_op;
  logic           w_use_imm, w_last, w_fin, w_jump;
  logic [IAW-1:0] w_jump_pc;

  assign w_op      = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_fn      = r_ir[5:0];
  assign w_imm     = sext16(r_ir[15:0]);
  assign w_wdst    = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_wdata   = (w_cls == CL_LW) ? r_mdr : r_alu;
  assign w_alu_b   = w_use_imm ? w_imm : r_b;
  assign w_last    = (r_pc == IAW'(IMEM_DEPTH - 1));
  assign w_exec_daddr = w_alu_y[DAW+1:2] & DAW'(DMEM_DEPTH - 1);
  assign w_mem_daddr  = r_alu[DAW+1:2] & DAW'(DMEM_DEPTH - 1);

  always_comb begin
    w_cls     = CL_NOP;
    w_alu_op  = ALU_ADD;
    w_use_imm = 1'b1;
    if (r_ir == HALT_WORD) begin
      w_cls = CL_HALT;
    end else begin
      case (w_op)
        OP_ADDI: w_cls = CL_ALU;
        OP_LW:   w_cls = CL_LW;
        OP_SW:   w_cls = CL_SW;
        OP_RTYPE: begin
          w_use_imm = 1'b0;
          w_cls     = CL_ALU;
          case (w_fn)
            FN_ADD:  w_alu_op = ALU_ADD;
            FN_SUB:  w_alu_op = ALU_SUB;
            FN_AND:  w_alu_op = ALU_AND;
            FN_OR:   w_alu_op = ALU_OR;
            FN_SLT:  w_alu_op = ALU_SLT;
            default: w_cls    = CL_NOP;
          endcase
        end
`ifdef MIPS_CPU_BRANCH_EN
        OP_BEQ:  w_cls = CL_BEQ;
        OP_BNE:  w_cls = CL_BNE;
        OP_J:    w_cls = CL_J;
`endif
        default: w_cls = CL_NOP;
      endcase
    end
  end

  mips_alu u_alu (
    .i_op (w_alu_op),
    .i_a  (r_a),
    .i_b  (w_alu_b),
    .o_y  (w_alu_y)
  );

  // w_fin marks the last cycle of an instruction; the common tail below picks the next pc.
  always_comb begin
    w_fin     = 1'b0;
    w_jump    = 1'b0;
    w_jump_pc = r_pc;
    case (r_state)
      S_EXEC:  w_fin = (w_cls == CL_BEQ) || (w_cls == CL_BNE) || (w_cls == CL_J);
      S_MEM:   w_fin = (w_cls == CL_SW);
      S_WB:    w_fin = 1'b1;
      default: w_fin = 1'b0;
    endcase
`ifdef MIPS_CPU_BRANCH_EN
    if (r_state == S_EXEC) begin
      if (w_cls == CL_J) begin
        w_jump    = 1'b1;
        w_jump_pc = r_ir[IAW-1:0];
      end else if ((w_cls == CL_BEQ && r_a == r_b) || (w_cls == CL_BNE && r_a != r_b)) begin
        w_jump    = 1'b1;
        w_jump_pc = r_pc + IAW'(1) + w_imm[IAW-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (imem_we && (r_state == S_IDLE || r_state == S_HALT))
      r_imem[imem_waddr] <= imem_wdata;
    if (reset && r_state == S_MEM && w_cls == CL_SW)
      r_dmem[w_mem_daddr] <= r_b;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_alu       <= '0;
      r_mdr       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc    <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_ir    <= r_imem[r_pc];
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
          if (w_cls == CL_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_alu   <= w_alu_y;
          r_state <= (w_cls == CL_LW || w_cls == CL_SW) ? S_MEM : S_WB;
          // out is registered here so it is visible during the store's MEM cycle
          if (w_cls == CL_SW && w_exec_daddr == DAW'(OUT_ADDR)) begin
            r_out       <= r_b;
            r_out_valid <= 1'b1;
          end
        end
        S_MEM: begin
          r_mdr   <= r_dmem[w_mem_daddr];
          r_state <= S_WB;
        end
        S_WB: begin
          if ((w_cls == CL_ALU || w_cls == CL_LW) && w_wdst != 5'd0)
            r_regs[w_wdst] <= w_wdata;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
      if (w_fin) begin
        if (w_jump) begin
          r_pc    <= w_jump_pc;
          r_state <= S_FETCH;
        end else if (w_last) begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
        end else begin
          r_pc    <= r_pc + IAW'(1);
          r_state <= S_FETCH;
        end
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign pc        = r_pc;
  assign halted    = r_halted;

endmodule

// File: doc/mips_multicycle_cpu.md
MIPS_MULTICYCLE_CPU -- requirements
Module: mips_multicycle_cpu

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 16, meaning instruction memory depth in words (power of 2, 4..1024).
REQ-002 SHALL have parameter DMEM_DEPTH, default 16, meaning data memory depth in words (power of 2, 1..1024).
REQ-003 SHALL have parameter OUT_ADDR, default 0, meaning the data word address mirrored onto `out`.
REQ-004 Port `clk`, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port `reset`, input, 1 bit: synchronous, active-low reset.
REQ-006 Port `start`, input, 1 bit: in IDLE, a one-cycle pulse begins execution at PC 0.
REQ-007 Port `imem_we`, input, 1 bit: instruction-memory write strobe, honoured only in IDLE or HALT.
REQ-008 Port `imem_waddr`, input, $clog2(IMEM_DEPTH) bits: instruction word address.
REQ-009 Port `imem_wdata`, input, 32 bits: instruction word.
REQ-010 Port `out`, output, 32 bits: last value stored to OUT_ADDR.
REQ-011 Port `out_valid`, output, 1 bit: one-cycle pulse in the cycle `out` updates.
REQ-012 Port `pc`, output, $clog2(IMEM_DEPTH) bits: current word PC.
REQ-013 Port `halted`, output, 1 bit: high while in HALT.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; IDLE->FETCH on `start`; HALT exits only on reset.
REQ-015 Cycle counts per instruction: addi/add/sub/and/or/slt 4 (F,D,E,WB); lw 5 (F,D,E,MEM,WB); sw 4 (F,D,E,MEM); beq/bne/j 3 (F,D,E).
REQ-016 Decode: addi 0x08 (sign-extended imm); R-type 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); lw 0x23; sw 0x2B; beq 0x04; bne 0x05; j 0x02.
REQ-017 Arithmetic SHALL be 32-bit two's complement, wrapping on overflow, no trap.
REQ-018 Register $0 SHALL always read 0; writes to it are discarded.
REQ-019 Memory word address SHALL be (rs+sext(imm))[31:2] modulo DMEM_DEPTH.
REQ-020 A sw whose word address equals OUT_ADDR SHALL also load `out` and pulse `out_valid` in its MEM cycle.
REQ-021 Branch target SHALL be pc+1+sext(imm) in words, modulo IMEM_DEPTH; j target SHALL be instr[25:0] modulo IMEM_DEPTH.
REQ-022 Instruction 0xFFFFFFFF SHALL enter HALT after its DECODE cycle; unknown opcodes/functs SHALL execute as NOP (4 cycles).
REQ-023 Sequential increment from pc = IMEM_DEPTH-1 SHALL enter HALT instead of wrapping; a taken branch or jump SHALL wrap.
REQ-024 `imem_we` outside IDLE/HALT SHALL be ignored.

Reset
REQ-025 With `reset` low at a rising edge: state IDLE, pc 0, out 0, out_valid 0, halted 0, all 32 registers 0, from any state including mid-instruction.
REQ-026 Instruction and data memory contents SHALL NOT be altered by reset.

Configuration
REQ-027 With macro MIPS_CPU_BRANCH_EN defined, beq/bne/j SHALL execute per REQ-021; when it is undefined, they SHALL execute as 4-cycle NOPs and no branch adder exists.

Structure
REQ-028 Package mips_cpu_pkg SHALL hold opcode/funct constants, the FSM state enum and the halt-word constant.
REQ-029 Sub-module mips_alu (combinational; ops add/sub/and/or/slt) SHALL be instantiated once.

Verification
REQ-030 Load addi $1,$0,5; addi $2,$0,10; add $3,$1,$2; sw $3,0($0); 0xFFFFFFFF; pulse start -> out=15, one out_valid pulse 16 cycles after start, then halted=1.
REQ-031 addi $0,$0,7; add $1,$0,$0; sw $1,0($0) -> out=0.
REQ-032 sw of 0x1234 to word 3, lw $5 from word 3, sw $5 to OUT_ADDR -> out=0x1234.
REQ-033 Countdown loop from $1=3 using bne -> exactly 3 iterations, final out=0; with MIPS_CPU_BRANCH_EN undefined -> straight-line result, out=2.
REQ-034 Program fills all IMEM_DEPTH words with NOPs -> halted=1 after the last word, pc=IMEM_DEPTH-1.
REQ-035 Assert reset mid-EXEC of add -> next cycle state IDLE, out=0, registers 0; restart reproduces REQ-030.
